// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port among NUM_REQ requesters, with a
// fixed-latency tag pipeline routing read data back. Optional lock feature: ARB_LOCK_EN.
module mem_port_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1,
   parameter int LOCK_MAX     = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
`ifdef ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]            lock,
`endif
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          mem_ready,
   output logic                          mem_rd_en,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic [DATA_WIDTH-1:0]         mem_rd_data,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [NUM_REQ-1:0]    tag_q [READ_LATENCY];
   logic [NUM_REQ-1:0]    tag_d [READ_LATENCY];
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic                  gnt_found;
   logic [PTR_W-1:0]      gnt_idx;
   logic [PTR_W-1:0]      cand;
   logic [PTR_W-1:0]      next_ptr;
   logic                  grant_en;
   logic [NUM_REQ-1:0]    tag_end;

`ifdef ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
   logic [PTR_W-1:0]      lock_owner_q, lock_owner_d;
   int                    lock_run;
`endif

   // Rotating search starting at ptr_q; first asserted request wins.
   // NOTE: every variable written in this block gets a default first, so no latch is inferred.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!gnt_found && req[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign grant_en  = reset && mem_ready && gnt_found;
   assign next_ptr  = PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
   assign gnt       = grant_en ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign mem_rd_en = grant_en;
   // The address bus parks on the last issued address between grants.
   assign mem_addr  = grant_en ? req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : mem_addr_q;

`ifdef ARB_LOCK_EN
   always_comb begin
      ptr_d        = ptr_q;
      lock_cnt_d   = lock_cnt_q;
      lock_owner_d = lock_owner_q;
      lock_run     = 0;
      if (grant_en) begin
         lock_owner_d = gnt_idx;
         if (lock[gnt_idx]) begin
            // A locked grant either extends the owner's run or starts a fresh one.
            lock_run = (gnt_idx == lock_owner_q) ? int'(lock_cnt_q) + 1 : 1;
            if (lock_run >= LOCK_MAX) begin
               ptr_d      = next_ptr;
               lock_cnt_d = '0;
            end else begin
               ptr_d      = gnt_idx;
               lock_cnt_d = CNT_W'(lock_run);
            end
         end else begin
            ptr_d      = next_ptr;
            lock_cnt_d = '0;
         end
      end else if (!lock[lock_owner_q]) begin
         lock_cnt_d = '0;
      end
   end
`else
   always_comb begin
      ptr_d = ptr_q;
      if (grant_en) begin
         ptr_d = next_ptr;
      end
   end
`endif

   // Tag pipeline: one-hot grant vectors travel alongside the memory latency.
   always_comb begin
      tag_d[0] = gnt;
      for (int j = 1; j < READ_LATENCY; j++) begin
         tag_d[j] = tag_q[j-1];
      end
   end

   assign tag_end     = tag_q[READ_LATENCY-1];
   assign mem_addr_d  = mem_addr;
   assign rsp_valid_d = tag_end;
   assign rsp_data_d  = (|tag_end) ? mem_rd_data : rsp_data_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q       <= '0;
         mem_addr_q  <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         for (int j = 0; j < READ_LATENCY; j++) begin
            tag_q[j] <= '0;
         end
`ifdef ARB_LOCK_EN
         lock_cnt_q   <= '0;
         lock_owner_q <= '0;
`endif
      end else begin
         ptr_q       <= ptr_d;
         mem_addr_q  <= mem_addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         for (int j = 0; j < READ_LATENCY; j++) begin
            tag_q[j] <= tag_d[j];
         end
`ifdef ARB_LOCK_EN
         lock_cnt_q   <= lock_cnt_d;
         lock_owner_q <= lock_owner_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single program/data memory read port between several requesters (opcode fetch, operand fetch, debug readout). It issues at most one read per cycle, tracks in-flight reads through a fixed-latency pipeline, and returns each read's data to the requester that issued it. It sits between the fetch/decode sequencers and the memory.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- ADDR_WIDTH, 8: memory address width.
- DATA_WIDTH, 8: memory word width.
- READ_LATENCY, 1: cycles from `mem_rd_en` to valid `mem_rd_data`, 1..4.
- LOCK_MAX, 4: maximum consecutive locked grants (used only with ARB_LOCK_EN).

- clk  input  1  clock.
- reset  input  1  synchronous, active-low.
- req  input  NUM_REQ  per-requester read request; held until granted.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- lock  input  NUM_REQ  per-requester lock request; present only with ARB_LOCK_EN.
- gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as the issued read.
- mem_ready  input  1  memory accepts a read this cycle.
- mem_rd_en  output  1  read strobe.
- mem_addr  output  ADDR_WIDTH  read address.
- mem_rd_data  input  DATA_WIDTH  read data, READ_LATENCY cycles after strobe.
- rsp_valid  output  NUM_REQ  one-hot, registered; data for that requester is valid.
- rsp_data  output  DATA_WIDTH  registered copy of `mem_rd_data`.

## Operation
- Priority pointer `ptr` (0..NUM_REQ-1): search starts at `ptr`, wraps modulo NUM_REQ; first asserted `req` wins.
- Grant only when `mem_ready`=1 and some `req`=1; otherwise `gnt`=0, `mem_rd_en`=0, `mem_addr` holds its previous value.
- On grant to i: `gnt[i]`=1, `mem_rd_en`=1, `mem_addr`=address of i, `ptr` <= (i+1) mod NUM_REQ at the clock edge.
- Requester drops `req` (or presents a new address) in the cycle after its grant; `req` held high after grant is a new request.
- Tag pipeline: READ_LATENCY-deep shift register of one-hot grant vectors; entry reaching the end selects the `rsp_valid` bit, and `mem_rd_data` is registered into `rsp_data` at that edge.
- Reads pipeline fully: one grant per cycle sustained; responses return in issue order.
- `rsp_data` holds its last value when `rsp_valid`=0.
- Simultaneous requests with all-equal priority: `ptr` decides; no requester waits more than NUM_REQ-1 grants (without lock).

## Timing
- Reset (reset=0 at clk edge): `ptr`=0, tag pipeline cleared, `rsp_valid`=0, `rsp_data`=0, `mem_addr` register=0, lock counter=0. `gnt`, `mem_rd_en` are 0 while reset is low.
- Reset mid-operation: all in-flight reads are discarded; no `rsp_valid` pulses after reset release for reads issued before it.
- Grant-to-response latency: `rsp_valid` rises READ_LATENCY+1 edges after the grant cycle's edge (grant in cycle N, `rsp_valid` high in cycle N+READ_LATENCY+1).
- `mem_ready`=0 stalls new grants only; in-flight reads still complete on schedule.

## Configuration
- ARB_LOCK_EN defined: `lock` port exists. If granted requester i has `lock[i]`=1, `ptr` stays at i, so i keeps top priority while `req[i]`=1. A counter limits this to LOCK_MAX consecutive grants; on the LOCK_MAX-th grant `ptr` advances normally and the counter clears. The counter also clears when a different requester is granted or `lock[i]` drops.
- ARB_LOCK_EN undefined: no `lock` port, no counter; pure round-robin.

## Test plan
- Single requester: req[0]=1, addr 0x10, READ_LATENCY=1, memory returns 0xA5 -> gnt[0] in cycle N, rsp_valid[0]=1 with rsp_data=0xA5 in cycle N+2.
- Contention: req=2'b11 held, NUM_REQ=2 -> grants alternate 0,1,0,1; each rsp_valid matches its issue order; one grant per cycle.
- Stall: mem_ready=0 for 3 cycles with req=2'b01 -> gnt=0, mem_rd_en=0 for 3 cycles; grant in the first cycle after mem_ready=1.
- Reset mid-flight: READ_LATENCY=3, two reads issued, reset low for 1 cycle -> no rsp_valid afterwards; next grant goes to requester 0.
- ARB_LOCK_EN, LOCK_MAX=4: lock[0]=1, req=2'b11 held -> requester 0 gets 4 consecutive grants, then requester 1 gets 1 grant.
- Wrap-around: NUM_REQ=3, ptr=2, req=3'b011 -> grant to 0, then ptr=1.
